// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) arbiter in front of a fixed-latency memory.
// One transaction in flight; round-robin on ties.
module mem_arbiter #(
    parameter int N   = 32,
    parameter int AW  = 12,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_valid,
    output logic          f_ready,
    input  logic [AW-1:0] f_addr,
    output logic          f_rsp_valid,
    output logic [N-1:0]  f_rdata,
    input  logic          d_valid,
    output logic          d_ready,
    input  logic [AW-1:0] d_addr,
    input  logic          d_we,
    input  logic [N-1:0]  d_wdata,
    input  logic [N-1:0]  d_mask,
    output logic          d_rsp_valid,
    output logic [N-1:0]  d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    output logic [N-1:0]  mem_mask,
    input  logic [N-1:0]  mem_rdata,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic          last_grant_reg;   // 1 = data was granted last
    logic          owner_reg;        // 1 = data owns the transaction
    logic          we_reg;
    logic [AW-1:0] addr_reg;
    logic [N-1:0]  wdata_reg;
    logic [N-1:0]  mask_reg;
    logic [N-1:0]  rdata_reg [2];    // index 0 = fetch, 1 = data
    logic          capture;
    logic          grant_f, grant_d;

    assign grant_f = f_valid && (!d_valid || last_grant_reg);
    assign grant_d = d_valid && (!f_valid || !last_grant_reg);
    assign f_ready = (state_reg == IDLE) && grant_f;
    assign d_ready = (state_reg == IDLE) && grant_d;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (f_ready || d_ready)
                    state_next = ISSUE;
            end
            ISSUE: begin
                state_next = WAIT;
                cnt_next   = LAT_CNT;
            end
            WAIT: begin
                // Memory data is valid on the final WAIT cycle only.
                if (cnt_reg <= 4'd1) begin
                    capture    = 1'b1;
                    cnt_next   = 4'd0;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            last_grant_reg <= 1'b1;
            owner_reg      <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            mask_reg       <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (f_ready || d_ready) begin
                owner_reg      <= d_ready;
                last_grant_reg <= d_ready;
                we_reg         <= d_ready && d_we;
                addr_reg       <= d_ready ? d_addr : f_addr;
                wdata_reg      <= d_ready ? d_wdata : '0;
                mask_reg       <= d_ready ? d_mask : '1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
            always_ff @(posedge clk) begin
                if (rst)
                    rdata_reg[gi] <= '0;
                else if (capture && (owner_reg == (gi == 1)))
                    rdata_reg[gi] <= we_reg ? '0 : mem_rdata;
            end
        end
    endgenerate

    assign f_rdata     = rdata_reg[0];
    assign d_rdata     = rdata_reg[1];
    assign f_rsp_valid = (state_reg == RESP) && !owner_reg;
    assign d_rsp_valid = (state_reg == RESP) && owner_reg;
    assign mem_en      = (state_reg == ISSUE);
    assign mem_we      = (state_reg == ISSUE) && we_reg;
    assign mem_addr    = addr_reg;
    assign mem_wdata   = wdata_reg;
    assign mem_mask    = mask_reg;
    assign busy        = (state_reg != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: LAT=2 main instance plus LAT=1 and LAT=15 instances.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cyc = 16'd0;
    logic        rd_mode;
    logic [31:0] rd_const;
    logic [31:0] mem_rdata;
    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] c0, c1, c2;

    logic        f_valid, d_valid, d_we;
    logic [11:0] f_addr, d_addr;
    logic [31:0] d_wdata, d_mask;
    logic        f_ready, d_ready, f_rsp_valid, d_rsp_valid, mem_en, mem_we, busy;
    logic [31:0] f_rdata, d_rdata, mem_wdata, mem_mask;
    logic [11:0] mem_addr;

    logic        zero1 = 1'b0;
    logic        a_fv, b_fv;
    logic        a_fr, a_dr, a_frsp, a_drsp, a_en, a_we, a_busy;
    logic        b_fr, b_dr, b_frsp, b_drsp, b_en, b_we, b_busy;
    logic [31:0] a_frd, a_drd, a_wd, a_mk, b_frd, b_drd, b_wd, b_mk;
    logic [11:0] a_ad, b_ad;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 16'd1;

    function automatic logic [31:0] pat(input logic [15:0] c);
        return 32'hC0DE0000 | {16'h0000, c};
    endfunction

    assign mem_rdata = rd_mode ? pat(cyc) : rd_const;

    mem_arbiter #(.N(32), .AW(12), .LAT(2)) u_dut (
        .clk(clk), .rst(rst),
        .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr),
        .f_rsp_valid(f_rsp_valid), .f_rdata(f_rdata),
        .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_mask(d_mask), .d_rsp_valid(d_rsp_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_mask(mem_mask), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.N(32), .AW(12), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst),
        .f_valid(a_fv), .f_ready(a_fr), .f_addr(f_addr),
        .f_rsp_valid(a_frsp), .f_rdata(a_frd),
        .d_valid(zero1), .d_ready(a_dr), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_mask(d_mask), .d_rsp_valid(a_drsp), .d_rdata(a_drd),
        .mem_en(a_en), .mem_we(a_we), .mem_addr(a_ad), .mem_wdata(a_wd),
        .mem_mask(a_mk), .mem_rdata(mem_rdata), .busy(a_busy)
    );

    mem_arbiter #(.N(32), .AW(12), .LAT(15)) u_lat15 (
        .clk(clk), .rst(rst),
        .f_valid(b_fv), .f_ready(b_fr), .f_addr(f_addr),
        .f_rsp_valid(b_frsp), .f_rdata(b_frd),
        .d_valid(zero1), .d_ready(b_dr), .d_addr(d_addr), .d_we(d_we),
        .d_wdata(d_wdata), .d_mask(d_mask), .d_rsp_valid(b_drsp), .d_rdata(b_drd),
        .mem_en(b_en), .mem_we(b_we), .mem_addr(b_ad), .mem_wdata(b_wd),
        .mem_mask(b_mk), .mem_rdata(mem_rdata), .busy(b_busy)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; rd_mode = 1'b0; rd_const = 32'h0;
        f_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0; a_fv = 1'b0; b_fv = 1'b0;
        f_addr = 12'h0; d_addr = 12'h0; d_wdata = 32'h0; d_mask = 32'h0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_f_rsp", f_rsp_valid, 0);
        chk("rst_d_rsp", d_rsp_valid, 0);
        chk("rst_f_rdata", f_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_mask", mem_mask, 0);

        // Single fetch, constant memory data
        rst = 1'b0; rd_const = 32'hDEADBEEF; f_valid = 1'b1; f_addr = 12'h010; #1;
        chk("f1_f_ready", f_ready, 1);
        chk("f1_d_ready", d_ready, 0);
        step(); f_valid = 1'b0;
        chk("f1_mem_en", mem_en, 1);
        chk("f1_mem_we", mem_we, 0);
        chk("f1_mem_addr", mem_addr, 32'h010);
        chk("f1_mem_mask", mem_mask, 32'hFFFFFFFF);
        chk("f1_busy", busy, 1);
        step(); chk("f1_wait_en", mem_en, 0);
        step(); chk("f1_wait_rsp", f_rsp_valid, 0);
        step(); chk("f1_rsp", f_rsp_valid, 1);
        chk("f1_d_rsp", d_rsp_valid, 0);
        chk("f1_rdata", f_rdata, 32'hDEADBEEF);
        step(); chk("f1_rsp_end", f_rsp_valid, 0);
        chk("f1_idle", busy, 0);

        // Fetch aborted by reset during WAIT
        f_valid = 1'b1; f_addr = 12'h020;
        step(); f_valid = 1'b0;
        step(); rst = 1'b1;
        step(); rst = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_f_rsp", f_rsp_valid, 0);
        chk("ab_mem_en", mem_en, 0);
        chk("ab_f_rdata", f_rdata, 0);
        step(); chk("ab_no_rsp", f_rsp_valid, 0);
        chk("ab_still_idle", busy, 0);

        // Tie after reset: fetch first, then alternate
        rd_mode = 1'b1; d_mask = 32'hFFFFFFFF;
        f_valid = 1'b1; f_addr = 12'h040; d_valid = 1'b1; d_we = 1'b0; d_addr = 12'h080;
        c0 = cyc; #1;
        chk("t1_f_ready", f_ready, 1);
        chk("t1_d_ready", d_ready, 0);
        step(); chk("t1_busy_f_ready", f_ready, 0);
        chk("t1_busy_d_ready", d_ready, 0);
        chk("t1_mem_addr", mem_addr, 32'h040);
        step(); step(); step();
        chk("t1_f_rsp", f_rsp_valid, 1);
        chk("t1_f_rdata", f_rdata, pat(c0 + 16'd3));
        step(); c1 = cyc;
        chk("t2_d_ready", d_ready, 1);
        chk("t2_f_ready", f_ready, 0);
        step(); chk("t2_mem_addr", mem_addr, 32'h080);
        step(); step(); step();
        chk("t2_d_rsp", d_rsp_valid, 1);
        chk("t2_f_rsp", f_rsp_valid, 0);
        chk("t2_d_rdata", d_rdata, pat(c1 + 16'd3));
        step(); c2 = cyc;
        chk("t3_f_ready", f_ready, 1);
        chk("t3_d_ready", d_ready, 0);
        step(); f_valid = 1'b0; d_valid = 1'b0;
        chk("t3_mem_addr", mem_addr, 32'h040);
        step(); step(); step();
        chk("t3_f_rsp", f_rsp_valid, 1);
        chk("t3_f_rdata", f_rdata, pat(c2 + 16'd3));
        chk("t3_d_rdata_held", d_rdata, pat(c1 + 16'd3));
        step();

        // Store: ack pulse, rdata captured as zero
        d_valid = 1'b1; d_we = 1'b1; d_addr = 12'h100; d_wdata = 32'h12345678; d_mask = 32'h0000FFFF; #1;
        chk("st_d_ready", d_ready, 1);
        step(); d_valid = 1'b0; d_we = 1'b0;
        chk("st_mem_en", mem_en, 1);
        chk("st_mem_we", mem_we, 1);
        chk("st_mem_addr", mem_addr, 32'h100);
        chk("st_mem_wdata", mem_wdata, 32'h12345678);
        chk("st_mem_mask", mem_mask, 32'h0000FFFF);
        step(); chk("st_we_low", mem_we, 0);
        step(); step();
        chk("st_d_rsp", d_rsp_valid, 1);
        chk("st_d_rdata", d_rdata, 0);
        chk("st_f_rdata_held", f_rdata, pat(c2 + 16'd3));
        step(); chk("st_idle", busy, 0);

        // LAT=1 and LAT=15 instances with changing memory data
        f_addr = 12'h0AA; a_fv = 1'b1; b_fv = 1'b1; c0 = cyc; #1;
        chk("l1_ready", a_fr, 1);
        chk("l15_ready", b_fr, 1);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k == 1) begin
                a_fv = 1'b0; b_fv = 1'b0;
                chk("l1_mem_en", a_en, 1);
                chk("l15_mem_en", b_en, 1);
            end
            chk($sformatf("l1_rsp_k%0d", k), a_frsp, (k == 3) ? 1 : 0);
            chk($sformatf("l15_rsp_k%0d", k), b_frsp, (k == 17) ? 1 : 0);
        end
        chk("l1_rdata", a_frd, pat(c0 + 16'd2));
        chk("l15_rdata", b_frd, pat(c0 + 16'd16));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter N, default 32, data/mask width.
REQ-002 SHALL have parameter AW, default 12, byte-address width.
REQ-003 SHALL have parameter LAT, default 2, memory read latency in cycles, legal range 1..15.
REQ-004 SHALL have ports:
  clk  in  1  single clock, all state on rising edge
  rst  in  1  synchronous, active-high reset
  f_valid  in  1  fetch request valid (read-only requester)
  f_ready  out  1  fetch request accepted this cycle
  f_addr  in  AW  fetch byte address
  f_rsp_valid  out  1  fetch response pulse
  f_rdata  out  N  fetch read data
  d_valid  in  1  data request valid
  d_ready  out  1  data request accepted this cycle
  d_addr  in  AW  data byte address
  d_we  in  1  1 = store, 0 = load
  d_wdata  in  N  store data
  d_mask  in  N  byte/bit write mask
  d_rsp_valid  out  1  data response pulse (load data or store ack)
  d_rdata  out  N  load data
  mem_en  out  1  memory access strobe
  mem_we  out  1  memory write enable
  mem_addr  out  AW  memory address
  mem_wdata  out  N  memory write data
  mem_mask  out  N  memory mask
  mem_rdata  in  N  memory read data, valid LAT cycles after the mem_en cycle
  busy  out  1  transaction in flight (state != IDLE)

Function
REQ-005 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-006 In IDLE, f_ready/d_ready SHALL be combinational: asserted only for the winner among valid requesters; both 0 in every other state.
REQ-007 Arbitration SHALL be: single valid requester wins; both valid -> requester not granted last (round-robin via 1-bit last_grant).
REQ-008 Handshake SHALL occur when valid && ready at a rising edge; arbiter latches owner, addr, we (0 for fetch), wdata, mask (all-ones for fetch), updates last_grant, goes to ISSUE.
REQ-009 Requesters SHALL hold valid and payload stable until ready; dropping valid before ready is legal and cancels nothing.
REQ-010 ISSUE SHALL last exactly one cycle with mem_en=1 and mem_* driven from latched values; then WAIT with counter loaded LAT.
REQ-011 WAIT SHALL last exactly LAT cycles, mem_en=0; on the last WAIT cycle mem_rdata SHALL be captured into the owner's rdata register; then RESP.
REQ-012 RESP SHALL last one cycle with owner's *_rsp_valid=1, other rsp_valid=0; then IDLE.
REQ-013 Latency SHALL be handshake cycle t -> rsp_valid at cycle t+LAT+2; back-to-back throughput one transaction per LAT+3 cycles.
REQ-014 For stores, rdata SHALL be captured as 0 and d_rsp_valid SHALL still pulse as store ack.
REQ-015 f_rdata/d_rdata SHALL hold their last captured value until the next capture for that requester.
REQ-016 mem_en, mem_we SHALL be 0 outside ISSUE; mem_addr/wdata/mask SHALL hold latched values in all states.
REQ-017 Requests arriving outside IDLE SHALL wait; no request SHALL be lost or duplicated.

Reset
REQ-018 While rst=1 at a rising edge: state=IDLE, last_grant=data (fetch wins first tie), counter=0, rdata regs=0, mem_* regs=0.
REQ-019 Reset mid-transaction SHALL abort it: no rsp_valid emitted, mem_en=0 next cycle, no pending grant retained.
REQ-020 All outputs SHALL be 0 in the cycle after reset, except ready signals, which follow REQ-006.

Verification
REQ-021 Fetch only, LAT=2, f_addr=0x010, mem_rdata=0xDEADBEEF -> f_ready cycle 0, mem_en cycle 1 addr 0x010 mask 0xFFFFFFFF, f_rsp_valid cycle 4, f_rdata=0xDEADBEEF.
REQ-022 Both valid after reset -> fetch granted first, data granted at next IDLE (cycle 5), then alternate while both remain valid.
REQ-023 Store d_addr=0x100, d_wdata=0x12345678, d_mask=0x0000FFFF -> one mem_en with mem_we=1 and those values, d_rsp_valid pulse with d_rdata=0.
REQ-024 rst asserted during WAIT -> busy=0 and no rsp_valid next cycle; subsequent fetch completes normally with fetch winning a tie.
REQ-025 LAT=1 and LAT=15 builds -> rsp_valid at t+3 and t+17 respectively; mem_rdata captured in exact cycle only (scoreboard with changing mem_rdata).
